// File: rtl/alu_arbiter.sv
// Two-requester ALU front end: round-robin grant in IDLE, one op in flight through
// EXEC and RESP, with a single shared result bus qualified by per-requester valids.
module alu_arbiter #(
    parameter int unsigned DSIZE = 16
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [DSIZE-1:0] req0_a,
    input  logic [DSIZE-1:0] req0_b,
    input  logic [2:0]       req0_op,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [DSIZE-1:0] req1_a,
    input  logic [DSIZE-1:0] req1_b,
    input  logic [2:0]       req1_op,

    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,

    output logic [DSIZE-1:0] rsp_out,
    output logic             rsp_zero,
    output logic             rsp_err,
    output logic [15:0]      op_count
);

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    state_e             state_q, state_d;
    logic               last_grant_q;
    logic               id_q;
    logic [DSIZE-1:0]   a_q, b_q;
    logic [2:0]         op_q;
    logic [DSIZE-1:0]   rsp_out_q;
    logic               rsp_zero_q, rsp_err_q;
    logic [15:0]        op_count_q;

    logic               gnt0, gnt1;
    logic               accept, consume;
    logic [DSIZE-1:0]   alu_res;
    logic               alu_err;

    // On contention the requester that did not win last time is favoured.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (req0_valid && req1_valid) begin
            gnt0 = last_grant_q;
            gnt1 = !last_grant_q;
        end else begin
            gnt0 = req0_valid;
            gnt1 = req1_valid;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = StExec;
            StExec:  state_d = StResp;
            StResp:  if (consume) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Handshake outputs; readies are masked while reset is held.
    always_comb begin
        req0_ready = (state_q == StIdle) && rst_n && gnt0;
        req1_ready = (state_q == StIdle) && rst_n && gnt1;
        rsp0_valid = (state_q == StResp) && !id_q;
        rsp1_valid = (state_q == StResp) && id_q;
    end

    assign accept  = req0_ready || req1_ready;
    assign consume = (rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready);

    always_comb begin
        alu_res = '0;
        alu_err = 1'b0;
        case (op_q)
            3'b000:  alu_res = a_q + b_q;
            3'b001:  alu_res = a_q - b_q;
            3'b010:  alu_res = a_q & b_q;
            3'b011:  alu_res = a_q ^ b_q;
            3'b100:  alu_res = a_q | b_q;
            3'b101:  alu_res = b_q;
            default: alu_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= 1'b1;
            id_q         <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= 3'b000;
        end else if (accept) begin
            last_grant_q <= req1_ready;
            id_q         <= req1_ready;
            a_q          <= req1_ready ? req1_a  : req0_a;
            b_q          <= req1_ready ? req1_b  : req0_b;
            op_q         <= req1_ready ? req1_op : req0_op;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_out_q  <= '0;
            rsp_zero_q <= 1'b0;
            rsp_err_q  <= 1'b0;
        end else if (state_q == StExec) begin
            rsp_out_q  <= alu_res;
            rsp_zero_q <= (alu_res == '0);
            rsp_err_q  <= alu_err;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count_q <= 16'd0;
        end else if (consume) begin
            op_count_q <= op_count_q + 16'd1;
        end
    end

    assign rsp_out  = rsp_out_q;
    assign rsp_zero = rsp_zero_q;
    assign rsp_err  = rsp_err_q;
    assign op_count = op_count_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: a transaction-level model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req1_valid, req0_ready, req1_ready;
    logic [15:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0]  req0_op, req1_op;
    logic        rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
    logic [15:0] rsp_out;
    logic        rsp_zero, rsp_err;
    logic [15:0] op_count;

    int n_checks = 0;
    int n_errors = 0;
    int grants[$];

    always #5 clk = ~clk;

    alu_arbiter #(.DSIZE(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_op    (req0_op),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_op    (req1_op),
        .rsp0_valid (rsp0_valid),
        .rsp0_ready (rsp0_ready),
        .rsp1_valid (rsp1_valid),
        .rsp1_ready (rsp1_ready),
        .rsp_out    (rsp_out),
        .rsp_zero   (rsp_zero),
        .rsp_err    (rsp_err),
        .op_count   (op_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] alu_ref(input logic [2:0] op, input logic [15:0] a,
                                            input logic [15:0] b);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a ^ b;
            3'd4:    return a | b;
            3'd5:    return b;
            default: return 16'h0000;
        endcase
    endfunction

    // Transaction model: an op is accepted, its result appears two cycles later and is
    // held until the owning requester consumes it.
    logic        m_busy, m_id, m_last, m_zero, m_err;
    int          m_age;
    logic [15:0] m_a, m_b, m_out, m_count;
    logic [2:0]  m_op;
    logic [1:0]  m_ready, m_rspv;

    assign m_ready = (!rst_n || m_busy) ? 2'b00 :
                     (req0_valid && req1_valid) ? (m_last ? 2'b01 : 2'b10) :
                     {req1_valid, req0_valid};
    assign m_rspv  = (m_busy && m_age == 2) ? (m_id ? 2'b10 : 2'b01) : 2'b00;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy  <= 1'b0;
            m_age   <= 0;
            m_id    <= 1'b0;
            m_last  <= 1'b1;
            m_count <= 16'd0;
            m_out   <= 16'd0;
            m_zero  <= 1'b0;
            m_err   <= 1'b0;
        end else if (!m_busy) begin
            if (m_ready != 2'b00) begin
                m_busy <= 1'b1;
                m_age  <= 1;
                m_id   <= m_ready[1];
                m_last <= m_ready[1];
                m_a    <= m_ready[1] ? req1_a  : req0_a;
                m_b    <= m_ready[1] ? req1_b  : req0_b;
                m_op   <= m_ready[1] ? req1_op : req0_op;
            end
        end else if (m_age == 1) begin
            m_age  <= 2;
            m_out  <= alu_ref(m_op, m_a, m_b);
            m_zero <= (alu_ref(m_op, m_a, m_b) == 16'h0000);
            m_err  <= (m_op > 3'd5);
        end else if (m_id ? rsp1_ready : rsp0_ready) begin
            m_busy  <= 1'b0;
            m_age   <= 0;
            m_count <= m_count + 16'd1;
        end
    end

    always @(negedge clk) begin
        check("req_ready", 32'({req1_ready, req0_ready}), 32'(m_ready));
        check("rsp_valid", 32'({rsp1_valid, rsp0_valid}), 32'(m_rspv));
        check("rsp_out",   32'(rsp_out),  32'(m_out));
        check("rsp_zero",  32'(rsp_zero), 32'(m_zero));
        check("rsp_err",   32'(rsp_err),  32'(m_err));
        check("op_count",  32'(op_count), 32'(m_count));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic rdy(input bit n);
        return n ? req1_ready : req0_ready;
    endfunction

    function automatic logic rspv(input bit n);
        return n ? rsp1_valid : rsp0_valid;
    endfunction

    task automatic drive(input bit n, input logic v, input logic [15:0] a, input logic [15:0] b,
                         input logic [2:0] op);
        if (n) begin
            req1_valid = v; req1_a = a; req1_b = b; req1_op = op;
        end else begin
            req0_valid = v; req0_a = a; req0_b = b; req0_op = op;
        end
    endtask

    task automatic set_rsp_ready(input bit n, input logic v);
        if (n) rsp1_ready = v;
        else   rsp0_ready = v;
    endtask

    task automatic do_op(input bit n, input logic [15:0] a, input logic [15:0] b,
                         input logic [2:0] op, input logic [15:0] eo, input logic ez,
                         input logic ee);
        int w;
        drive(n, 1'b1, a, b, op);
        #1;
        w = 0;
        while (!rdy(n) && w < 20) begin
            step();
            w++;
        end
        check($sformatf("grant_req%0d", n), 32'(rdy(n)), 32'd1);
        step();
        drive(n, 1'b0, a, b, op);
        w = 1;
        while (!rspv(n) && w < 10) begin
            step();
            w++;
        end
        check("latency", 32'(w), 32'd2);
        check($sformatf("lit_out_op%0d", op), 32'(rsp_out), 32'(eo));
        check("lit_zero", 32'(rsp_zero), 32'(ez));
        check("lit_err",  32'(rsp_err),  32'(ee));
        set_rsp_ready(n, 1'b1);
        step();
        set_rsp_ready(n, 1'b0);
    endtask

    initial begin
        int cyc;
        rst_n = 1'b0;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = '0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = '0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;

        // Reset state, with a request already presented
        repeat (2) step();
        drive(0, 1'b1, 16'h0005, 16'h0003, 3'b001);
        #1;
        check("rst_req0_ready", 32'(req0_ready), 32'd0);
        check("rst_rsp_out",    32'(rsp_out),    32'd0);
        check("rst_rsp_zero",   32'(rsp_zero),   32'd0);
        check("rst_op_count",   32'(op_count),   32'd0);
        rst_n = 1'b1;

        // First edge after reset release accepts
        do_op(0, 16'h0005, 16'h0003, 3'b001, 16'h0002, 1'b0, 1'b0);
        check("lit_count_1", 32'(op_count), 32'd1);
        do_op(1, 16'hFFFF, 16'h0001, 3'b000, 16'h0000, 1'b1, 1'b0);
        do_op(0, 16'h1234, 16'h1234, 3'b011, 16'h0000, 1'b1, 1'b0);
        do_op(1, 16'hF0F0, 16'h3C3C, 3'b010, 16'h3030, 1'b0, 1'b0);
        do_op(0, 16'hF000, 16'h000F, 3'b100, 16'hF00F, 1'b0, 1'b0);
        do_op(1, 16'hAAAA, 16'h5555, 3'b101, 16'h5555, 1'b0, 1'b0);
        do_op(0, 16'h0003, 16'h0005, 3'b001, 16'hFFFE, 1'b0, 1'b0);
        do_op(1, 16'h1234, 16'h5678, 3'b111, 16'h0000, 1'b1, 1'b1);
        do_op(0, 16'h0009, 16'h0009, 3'b110, 16'h0000, 1'b1, 1'b1);
        check("lit_count_9", 32'(op_count), 32'd9);

        // Continuous contention after reset alternates 0,1,0,1
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        drive(0, 1'b1, 16'd1, 16'd2, 3'b000);
        drive(1, 1'b1, 16'd10, 16'd4, 3'b001);
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        #1;
        cyc = 0;
        while (grants.size() < 4 && cyc < 40) begin
            if (req0_ready) grants.push_back(0);
            if (req1_ready) grants.push_back(1);
            if (rsp0_valid) check("rr_rsp0_out", 32'(rsp_out), 32'd3);
            if (rsp1_valid) check("rr_rsp1_out", 32'(rsp_out), 32'd6);
            step();
            cyc++;
        end
        check("rr_grant_count", 32'(grants.size()), 32'd4);
        foreach (grants[i]) check($sformatf("rr_grant%0d", i), 32'(grants[i]), 32'(i % 2));
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (3) step();
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        check("lit_count_rr", 32'(op_count), 32'd4);

        // Backpressure on requester 1 while requester 0 waits
        drive(1, 1'b1, 16'h0007, 16'h0009, 3'b101);
        #1;
        check("bp_req1_ready", 32'(req1_ready), 32'd1);
        step();
        req1_valid = 1'b0;
        step();
        check("bp_rsp1_valid", 32'(rsp1_valid), 32'd1);
        drive(0, 1'b1, 16'h0100, 16'h0023, 3'b000);
        rsp0_ready = 1'b1;
        #1;
        for (int i = 0; i < 5; i++) begin
            check("bp_req0_ready", 32'(req0_ready), 32'd0);
            check("bp_rsp_out",    32'(rsp_out),    32'h9);
            check("bp_rsp1_hold",  32'(rsp1_valid), 32'd1);
            step();
        end
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b1;
        step();
        rsp1_ready = 1'b0;
        check("bp_req0_grant", 32'(req0_ready), 32'd1);
        step();
        check("bp_req0_taken", 32'(req0_ready), 32'd0);
        req0_valid = 1'b0;
        step();
        check("bp_rsp0_valid", 32'(rsp0_valid), 32'd1);
        check("bp_rsp0_out",   32'(rsp_out),    32'h0123);
        rsp0_ready = 1'b1;
        step();
        rsp0_ready = 1'b0;
        check("lit_count_bp", 32'(op_count), 32'd6);

        // Reset during RESP drops the response and restores req0 priority
        drive(1, 1'b1, 16'h0002, 16'h0002, 3'b000);
        step();
        req1_valid = 1'b0;
        step();
        check("mr_rsp1_valid", 32'(rsp1_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mr_rsp1_drop", 32'(rsp1_valid), 32'd0);
        check("mr_op_count",  32'(op_count),   32'd0);
        rst_n = 1'b1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        check("mr_req0_wins", 32'({req1_ready, req0_ready}), 32'b01);
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        step();
        check("mr_rsp0_valid", 32'(rsp0_valid), 32'd1);
        rsp0_ready = 1'b1;
        step();
        rsp0_ready = 1'b0;
        check("lit_count_mr", 32'(op_count), 32'd1);

        repeat (2) step();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors",
                 n_checks, n_errors);
        $fatal(1);
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: DSIZE, default 16, operand/result width in bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 reqN_valid  input  1  (N=0,1) requester N presents an operation.
REQ-005 reqN_ready  output  1  (N=0,1) arbiter accepts requester N's operation this cycle.
REQ-006 reqN_a, reqN_b  input  DSIZE  (N=0,1) operands A and B.
REQ-007 reqN_op  input  3  (N=0,1) operation code.
REQ-008 rspN_valid  output  1  (N=0,1) result for requester N available.
REQ-009 rspN_ready  input  1  (N=0,1) requester N consumes the result.
REQ-010 rsp_out  output  DSIZE  result, shared by both response ports, qualified by rspN_valid.
REQ-011 rsp_zero  output  1  high when rsp_out equals 0.
REQ-012 rsp_err  output  1  high when the executed op code was illegal.
REQ-013 op_count  output  16  number of completed responses.

Function
REQ-014 Op table: 000 A+B; 001 A-B; 010 A&B; 011 A^B; 100 A|B; 101 B; 110/111 illegal, result 0.
REQ-015 Arithmetic is modulo 2^DSIZE; no carry, overflow or borrow output exists.
REQ-016 FSM states: IDLE, EXEC, RESP; exactly one operation is in flight at any time.
REQ-017 reqN_ready is high only in IDLE, for at most one N; it is combinational from the reqN_valid inputs and the last_grant register.
REQ-018 Arbitration in IDLE: a single valid requester is granted; if both are valid, the requester not equal to last_grant is granted.
REQ-019 Accept occurs at an edge where the state is IDLE and reqN_valid and reqN_ready are both high; at that edge the block latches a, b, op and N, updates last_grant to N, and moves to EXEC.
REQ-020 EXEC lasts one cycle; at its closing edge the block registers rsp_out, rsp_zero and rsp_err, then moves to RESP.
REQ-021 In RESP, rspN_valid is high for the latched N only; rsp_out, rsp_zero and rsp_err stay stable until the consuming edge.
REQ-022 Consuming edge: RESP with rspN_ready high; the block moves to IDLE and increments op_count, wrapping from 0xFFFF to 0x0000.
REQ-023 Latency: rspN_valid rises 2 cycles after the accept edge; minimum issue interval is 3 cycles.
REQ-024 rspN_ready is ignored outside RESP, and the non-granted requester's rsp_ready is ignored in RESP.
REQ-025 reqN_valid deasserting outside IDLE has no effect; latched operands are used.
REQ-026 An illegal op returns rsp_out=0, rsp_zero=1, rsp_err=1 and still completes and counts.

Reset
REQ-027 When rst_n is low, the block immediately enters IDLE, with last_grant=1, rsp_out=0, rsp_zero=0, rsp_err=0, op_count=0, and all reqN_ready and rspN_valid low.
REQ-028 Reset asserted in EXEC or RESP discards the in-flight operation with no response and no count.
REQ-029 The first edge after rst_n rises may accept a request.

Verification
REQ-030 Single op: req0 valid with a=0x0005, b=0x0003, op=001 -> req0_ready high in the same cycle; rsp0_valid high 2 cycles later with rsp_out=0x0002, zero=0, err=0; op_count=1 after rsp0_ready.
REQ-031 Both requesters continuously valid after reset -> grant order 0,1,0,1; each response goes only to its own rspN_valid.
REQ-032 Zero and wrap: a=0xFFFF, b=0x0001, op=000 -> rsp_out=0x0000, rsp_zero=1; a=0x1234, b=0x1234, op=011 -> rsp_out=0, zero=1.
REQ-033 Illegal op 111 -> rsp_out=0, zero=1, err=1; op_count increments.
REQ-034 Backpressure: rsp1_ready held low for 5 cycles with req0 valid -> rsp_out stable, req0_ready low throughout; req0 is accepted in the cycle after rsp1_ready is sampled high.
REQ-035 rst_n pulsed low during RESP -> rspN_valid low immediately, op_count=0, req0 wins the next contention.
